period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the waveform of a single-bit input: high time, low time and period, counted in cycles of the system clock.
- It sits opposite the clock/tick generators in the design and characterises a generated waveform in hardware.
- Typical uses are self-checking benches and on-chip frequency monitors.
- One measurement is taken per start request; the result is returned on a valid/ready handshake.

Parameters:
- CNT_W, 16: width of each high/low counter; the saturation value is 2^CNT_W-1.
- SYNC_STAGES, 2: number of flops in the input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts asynchronously, released synchronously by the integrator.
- sig_in  in  1  waveform under measurement; asynchronous to clk.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE.
- busy  out  1  high whenever state != IDLE.
- high_cnt  out  CNT_W  cycles the input was high.
- low_cnt  out  CNT_W  cycles the input was low.
- period_cnt  out  CNT_W+1  high_cnt + low_cnt, zero-extended sum with no overflow.
- timeout  out  1  result is saturated; an edge was missing.
- valid  out  1  result valid.
- ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, any state, mid-measurement included):
  - state = IDLE; synchroniser and edge-history flops = 0.
  - All outputs = 0.
- Input path:
  - sig_in passes through the SYNC_STAGES-flop chain to give s; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Pin-to-edge-detect latency is SYNC_STAGES+1 cycles.
- Internal counter cnt is CNT_W bits wide.
- FSM states:
  - IDLE: if start, go to ARM. start is ignored in all other states.
  - ARM:
    - on rise: cnt = 1, go to MEAS_HIGH;
    - otherwise cnt increments. At cnt = 2^CNT_W-1: high_cnt = low_cnt = all-ones, timeout = 1, go to DONE.
    - Any level present when start arrives is discarded until the first rise.
  - MEAS_HIGH:
    - on fall: high_cnt = cnt, cnt = 1, go to MEAS_LOW;
    - otherwise, at cnt = all-ones: high_cnt = low_cnt = all-ones, timeout = 1, go to DONE;
    - otherwise cnt increments.
  - MEAS_LOW:
    - on rise: low_cnt = cnt, go to DONE;
    - otherwise, at cnt = all-ones: low_cnt = all-ones, timeout = 1, go to DONE;
    - otherwise cnt increments.
  - DONE:
    - valid = 1; high_cnt, low_cnt, period_cnt and timeout are held stable.
    - Input edges are ignored.
    - When valid & ready: go to IDLE. valid, timeout and busy drop on the next cycle; the count outputs keep their last values.
- Result: an input held high for H synchronised cycles and low for L cycles yields high_cnt = H, low_cnt = L, period_cnt = H+L.
- Output latency: valid rises on the cycle after the terminating rise is detected.
- ready asserted before valid has no effect. ready high in the same cycle valid rises still gives a valid pulse of at least one cycle.
- period_cnt is registered, updated in the same cycle as low_cnt.
- A start pulse coincident with valid & ready is ignored; the FSM is in DONE that cycle.

Optional Feature:
- Macro: PERIOD_METER_GLITCH_FILTER_EN.
- Defined:
  - s is replaced by a filtered level that changes only after 3 consecutive equal synchroniser outputs.
  - Pulses shorter than 3 cycles are ignored.
  - Pin-to-edge-detect latency becomes SYNC_STAGES+3.
  - The filter resets to 0.
- Undefined: no filter. Every synchronised transition counts, including 1-cycle pulses.

Test Plan:
- Reset: hold rst_n = 0 with sig_in toggling, release -> busy = valid = timeout = 0, all counts 0; no state change without start.
- Basic: start, sig_in repeating 5 high / 3 low -> valid with high_cnt = 5, low_cnt = 3, period_cnt = 8, timeout = 0; after ready, busy = 0.
- Backpressure: complete a measurement, hold ready = 0 for 10 cycles with sig_in toggling -> valid held, counts unchanged. Assert ready -> valid = 0 on the next cycle.
- Timeout: CNT_W = 4, start with sig_in constant 0 -> DONE after 15 ARM cycles, timeout = 1, high_cnt = low_cnt = 15, period_cnt = 30.
- Mid-operation: start pulsed during MEAS_HIGH has no effect. Then rst_n = 0 mid MEAS_HIGH -> outputs 0 immediately (asynchronously), FSM in IDLE; a new start measures correctly.
- Glitch pulse: sig_in low 20, high 1, low 10, high 6, low 4:
  - without the macro -> high_cnt = 1, low_cnt = 10;
  - with PERIOD_METER_GLITCH_FILTER_EN -> high_cnt = 6, low_cnt = 4.

Source files
------------

// File: rtl/period_meter_if.sv
// Result/handshake bundle for period_meter.
// The meter drives the measured counts and the valid flag through the master
// modport. The consumer drives start and ready through the slave modport.
interface period_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period_cnt;
    logic             timeout;
    logic             valid;
    logic             ready;

    modport master (
        input  start,
        input  ready,
        output busy,
        output high_cnt,
        output low_cnt,
        output period_cnt,
        output timeout,
        output valid
    );

    modport slave (
        output start,
        output ready,
        input  busy,
        input  high_cnt,
        input  low_cnt,
        input  period_cnt,
        input  timeout,
        input  valid
    );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures high time, low time and period of an asynchronous
// single-bit waveform in system-clock cycles. One measurement is taken per
// start request, and the result is handed over on a valid/ready handshake.
//
// Optional build macro PERIOD_METER_GLITCH_FILTER_EN: when it is defined,
// the synchronised level must hold for three consecutive samples before the
// meter sees it, so pulses shorter than three cycles are ignored.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sig_in,
    period_meter_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEAS_HIGH,
        S_MEAS_LOW,
        S_DONE
    } state_t;

    // Zero-extended sum of two counts; the extra bit means it cannot overflow.
    function automatic logic [CNT_W:0] f_period(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Counter step that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] f_inc_sat(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    logic                   w_s;
    logic                   r_s_d;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       w_high_nxt;
    logic [CNT_W-1:0]       r_low;
    logic [CNT_W-1:0]       w_low_nxt;
    logic [CNT_W:0]         r_period;
    logic [CNT_W:0]         w_period_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;

    // Synchroniser chain: sig_in enters bit 0 and the top bit is the clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // The filtered level follows the synchroniser once three samples in a row
    // agree. Otherwise it keeps its previous value. It is combinational on the
    // history so that the filter adds only two cycles of delay.
    assign w_s = ((w_sync_out == r_hist[0]) && (w_sync_out == r_hist[1]))
                 ? w_sync_out : r_filt;

    // History of the two previous synchroniser samples and the held filter level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], w_sync_out};
            r_filt <= w_s;
        end
    end
`else
    assign w_s = w_sync_out;
`endif

    // One-cycle delayed copy of the level, used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter and result updates. In every branch, cnt already
    // holds the number of cycles spent in the current phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_high_nxt    = r_high;
        w_low_nxt     = r_low;
        w_period_nxt  = r_period;
        w_timeout_nxt = r_timeout;
        w_valid_nxt   = r_valid;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            S_ARM: begin
                if (w_rise) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_MEAS_HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_high_nxt    = CNT_MAX;
                    w_low_nxt     = CNT_MAX;
                    w_period_nxt  = f_period(CNT_MAX, CNT_MAX);
                    w_timeout_nxt = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = f_inc_sat(r_cnt);
                end
            end

            S_MEAS_HIGH: begin
                if (w_fall) begin
                    w_high_nxt  = r_cnt;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_MEAS_LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_high_nxt    = CNT_MAX;
                    w_low_nxt     = CNT_MAX;
                    w_period_nxt  = f_period(CNT_MAX, CNT_MAX);
                    w_timeout_nxt = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = f_inc_sat(r_cnt);
                end
            end

            S_MEAS_LOW: begin
                if (w_rise) begin
                    w_low_nxt    = r_cnt;
                    w_period_nxt = f_period(r_high, r_cnt);
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_low_nxt     = CNT_MAX;
                    w_period_nxt  = f_period(r_high, CNT_MAX);
                    w_timeout_nxt = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt = f_inc_sat(r_cnt);
                end
            end

            S_DONE: begin
                // Edges and start are ignored here. The counts stay after the
                // handshake, and only the flags drop.
                if (r_valid && bus.ready) begin
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Phase counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_high    <= '0;
            r_low     <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_high    <= w_high_nxt;
            r_low     <= w_low_nxt;
            r_period  <= w_period_nxt;
            r_timeout <= w_timeout_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.high_cnt   = r_high;
    assign bus.low_cnt    = r_low;
    assign bus.period_cnt = r_period;
    assign bus.timeout    = r_timeout;
    assign bus.valid      = r_valid;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter. Instance 0 uses CNT_W=16 and instance 1 uses
// CNT_W=4, which makes the saturation cases short. Expected results come from
// a run-length model of the driven waveform.
`timescale 1ns/1ps
module tb_period_meter;

    logic clk;
    logic rst_n;

    logic drv_sig   [2];
    logic drv_start [2];
    logic drv_ready [2];

    logic sig_a;
    logic sig_b;

    period_meter_if #(.CNT_W(16)) bus_a ();
    period_meter_if #(.CNT_W(4))  bus_b ();

    assign sig_a       = drv_sig[0];
    assign sig_b       = drv_sig[1];
    assign bus_a.start = drv_start[0];
    assign bus_a.ready = drv_ready[0];
    assign bus_b.start = drv_start[1];
    assign bus_b.ready = drv_ready[1];

    period_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_a),
        .bus    (bus_a)
    );

    period_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_b),
        .bus    (bus_b)
    );

    logic        obs_valid [2];
    logic        obs_busy  [2];
    logic        obs_tmo   [2];
    int unsigned obs_high  [2];
    int unsigned obs_low   [2];
    int unsigned obs_per   [2];

    assign obs_valid[0] = bus_a.valid;
    assign obs_busy[0]  = bus_a.busy;
    assign obs_tmo[0]   = bus_a.timeout;
    assign obs_high[0]  = 32'(bus_a.high_cnt);
    assign obs_low[0]   = 32'(bus_a.low_cnt);
    assign obs_per[0]   = 32'(bus_a.period_cnt);
    assign obs_valid[1] = bus_b.valid;
    assign obs_busy[1]  = bus_b.busy;
    assign obs_tmo[1]   = bus_b.timeout;
    assign obs_high[1]  = 32'(bus_b.high_cnt);
    assign obs_low[1]   = 32'(bus_b.low_cnt);
    assign obs_per[1]   = 32'(bus_b.period_cnt);

    int checks   = 0;
    int failures = 0;

    int unsigned e_high [2];
    int unsigned e_low  [2];
    int unsigned e_per  [2];
    logic        e_tmo  [2];

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    localparam int BASIC_LAT = 13;
`else
    localparam int BASIC_LAT = 11;
`endif

    typedef struct {
        int unsigned high;
        int unsigned low;
        int unsigned per;
        bit          tmo;
    } res_t;

    bit pat_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned maxv_of(input int d);
        return (d == 0) ? 32'd65535 : 32'd15;
    endfunction

    task automatic add(input bit v, input int n);
        for (int i = 0; i < n; i++) pat_q.push_back(v);
    endtask

    // Level at waveform index i. Indices 0..2 are the settled pre-start level.
    // After the pattern ends, the last level is held.
    function automatic bit lvl(input bit pre, input int i);
        if (i < 3) return pre;
        if (i - 3 < pat_q.size()) return pat_q[i-3];
        if (pat_q.size() == 0) return pre;
        return pat_q[pat_q.size()-1];
    endfunction

    // Run-length model. It finds the first rise after start, then measures the
    // run of ones and the run of zeros. A run longer than maxv saturates.
    function automatic res_t model(input bit pre, input int unsigned maxv);
        res_t        r;
        bit          prev;
        bit          cur;
        bit          raw;
        int          phase;
        int unsigned run;
        int          lim;
`ifdef PERIOD_METER_GLITCH_FILTER_EN
        bit          f;
        f = pre;
`endif
        r.high = maxv;
        r.low  = maxv;
        r.per  = 2 * maxv;
        r.tmo  = 1'b1;
        prev   = pre;
        phase  = 0;
        run    = 0;
        lim    = pat_q.size() + 3 + 2 * int'(maxv) + 16;
        for (int i = 3; i < lim; i++) begin
            raw = lvl(pre, i);
`ifdef PERIOD_METER_GLITCH_FILTER_EN
            if (raw == lvl(pre, i-1) && raw == lvl(pre, i-2)) f = raw;
            cur = f;
`else
            cur = raw;
`endif
            if (phase == 0) begin
                if (cur && !prev) begin
                    phase = 1;
                    run   = 1;
                end
            end else if (phase == 1) begin
                if (!cur) begin
                    r.high = run;
                    phase  = 2;
                    run    = 1;
                end else begin
                    run++;
                    if (run > maxv) return r;
                end
            end else begin
                if (cur) begin
                    r.low = run;
                    r.per = r.high + run;
                    r.tmo = 1'b0;
                    return r;
                end
                run++;
                if (run > maxv) begin
                    r.per = r.high + maxv;
                    return r;
                end
            end
            prev = cur;
        end
        return r;
    endfunction

    // Whenever a result is presented, it must match the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (obs_valid[d]) begin
                    check($sformatf("d%0d high_cnt", d), obs_high[d], e_high[d]);
                    check($sformatf("d%0d low_cnt", d), obs_low[d], e_low[d]);
                    check($sformatf("d%0d period_cnt", d), obs_per[d], e_per[d]);
                    check($sformatf("d%0d timeout", d), obs_tmo[d], e_tmo[d]);
                    check($sformatf("d%0d busy with valid", d), obs_busy[d], 1);
                end
            end
        end
    end

    task automatic check_zero(input int d, input string tag);
        check({tag, " busy"}, obs_busy[d], 0);
        check({tag, " valid"}, obs_valid[d], 0);
        check({tag, " timeout"}, obs_tmo[d], 0);
        check({tag, " high_cnt"}, obs_high[d], 0);
        check({tag, " low_cnt"}, obs_low[d], 0);
        check({tag, " period_cnt"}, obs_per[d], 0);
    endtask

    // One full measurement on instance d using the waveform in pat_q.
    task automatic measure(input int d, input bit pre, input int hold,
                           input int mid_start, input bit early_rdy,
                           input bit start_at_ack, input string tag,
                           output int lat);
        res_t m;
        bit   got;
        bit   last;
        int   limit;
        m         = model(pre, maxv_of(d));
        e_high[d] = m.high;
        e_low[d]  = m.low;
        e_per[d]  = m.per;
        e_tmo[d]  = m.tmo;
        last      = (pat_q.size() > 0) ? pat_q[pat_q.size()-1] : pre;
        limit     = (d == 0) ? 400 : 120;
        lat       = 0;
        got       = 1'b0;
        drv_ready[d] = 1'b0;
        drv_sig[d]   = pre;
        repeat (8) @(negedge clk);
        drv_ready[d] = early_rdy;
        drv_start[d] = 1'b1;
        drv_sig[d]   = (pat_q.size() > 0) ? pat_q[0] : pre;
        for (int n = 1; n <= limit && !got; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, " busy after start"}, obs_busy[d], 1);
            if (obs_valid[d]) begin
                got          = 1'b1;
                lat          = n;
                drv_start[d] = 1'b0;
            end else begin
                drv_start[d] = (n == mid_start);
                drv_sig[d]   = (n < pat_q.size()) ? pat_q[n] : last;
            end
        end
        if (!got) begin
            check({tag, " valid seen"}, 0, 1);
            drv_ready[d] = 1'b0;
            drv_start[d] = 1'b0;
            return;
        end
        if (!early_rdy) begin
            for (int n = 0; n < hold; n++) begin
                drv_sig[d] = ~drv_sig[d];
                @(negedge clk);
                check({tag, " valid held"}, obs_valid[d], 1);
            end
            drv_ready[d] = 1'b1;
            drv_start[d] = start_at_ack;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        drv_ready[d] = 1'b0;
        drv_start[d] = 1'b0;
        check({tag, " valid after ack"}, obs_valid[d], 0);
        check({tag, " busy after ack"}, obs_busy[d], 0);
        check({tag, " timeout after ack"}, obs_tmo[d], 0);
        check({tag, " high kept"}, obs_high[d], m.high);
        check({tag, " low kept"}, obs_low[d], m.low);
        check({tag, " period kept"}, obs_per[d], m.per);
    endtask

    task automatic basic_pattern();
        pat_q.delete();
        for (int i = 0; i < 4; i++) begin
            add(1'b1, 5);
            add(1'b0, 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        int   lat;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drv_sig[d]   = 1'b0;
            drv_start[d] = 1'b0;
            drv_ready[d] = 1'b0;
            e_high[d]    = 0;
            e_low[d]     = 0;
            e_per[d]     = 0;
            e_tmo[d]     = 1'b0;
        end

        // Pin the model with hand-computed results.
        basic_pattern();
        m = model(1'b0, 65535);
        check("model basic high", m.high, 5);
        check("model basic low", m.low, 3);
        check("model basic period", m.per, 8);
        check("model basic timeout", m.tmo, 0);
        pat_q.delete();
        m = model(1'b0, 15);
        check("model arm timeout period", m.per, 30);
        check("model arm timeout flag", m.tmo, 1);
        add(1'b1, 3);
        add(1'b0, 1);
        m = model(1'b0, 15);
        check("model low timeout period", m.per, 18);

        // Reset held while the inputs toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv_sig[0] = ~drv_sig[0];
            drv_sig[1] = ~drv_sig[1];
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero(0, "reset a");
        check_zero(1, "reset b");
        for (int i = 0; i < 10; i++) begin
            drv_sig[0] = ~drv_sig[0];
            drv_sig[1] = ~drv_sig[1];
            @(negedge clk);
        end
        check("idle a busy", obs_busy[0], 0);
        check("idle a valid", obs_valid[0], 0);
        check("idle b busy", obs_busy[1], 0);

        // Basic 5 high / 3 low, with ready already high before valid.
        basic_pattern();
        measure(0, 1'b0, 0, 0, 1'b1, 1'b0, "basic", lat);
        check("basic latency", lat, BASIC_LAT);

        // Backpressure, plus a start that arrives together with the handshake.
        basic_pattern();
        measure(0, 1'b0, 10, 0, 1'b0, 1'b1, "backpressure", lat);

        // A start during MEAS_HIGH is ignored.
        basic_pattern();
        measure(0, 1'b0, 2, 5, 1'b0, 1'b0, "mid start", lat);

        // A high level present at start is discarded until the first rise.
        pat_q.delete();
        add(1'b1, 4);
        add(1'b0, 4);
        add(1'b1, 7);
        add(1'b0, 4);
        add(1'b1, 4);
        measure(0, 1'b1, 3, 0, 1'b0, 1'b0, "pre high", lat);

        // Glitch pulse.
        pat_q.delete();
        add(1'b0, 20);
        add(1'b1, 1);
        add(1'b0, 10);
        add(1'b1, 6);
        add(1'b0, 4);
        add(1'b1, 8);
        m = model(1'b0, 65535);
`ifdef PERIOD_METER_GLITCH_FILTER_EN
        check("model glitch high", m.high, 6);
        check("model glitch low", m.low, 4);
`else
        check("model glitch high", m.high, 1);
        check("model glitch low", m.low, 10);
`endif
        measure(0, 1'b0, 1, 0, 1'b0, 1'b0, "glitch", lat);

        // Saturation cases on the narrow instance.
        pat_q.delete();
        measure(1, 1'b0, 2, 0, 1'b0, 1'b0, "arm timeout", lat);
        check("arm timeout latency", lat, 16);
        pat_q.delete();
        add(1'b1, 3);
        add(1'b0, 1);
        measure(1, 1'b0, 2, 0, 1'b0, 1'b0, "low timeout", lat);
        pat_q.delete();
        add(1'b1, 1);
        measure(1, 1'b0, 2, 0, 1'b0, 1'b0, "high timeout", lat);
        pat_q.delete();
        add(1'b1, 15);
        add(1'b0, 2);
        add(1'b1, 4);
        m = model(1'b0, 15);
        check("model exact max high", m.high, 15);
        measure(1, 1'b0, 2, 0, 1'b0, 1'b0, "exact max", lat);

        // Asynchronous reset in the middle of MEAS_HIGH.
        drv_sig[0] = 1'b0;
        repeat (8) @(negedge clk);
        drv_start[0] = 1'b1;
        drv_sig[0]   = 1'b1;
        @(negedge clk);
        drv_start[0] = 1'b0;
        repeat (6) @(negedge clk);
        drv_start[0] = 1'b1;
        @(negedge clk);
        drv_start[0] = 1'b0;
        check("midop busy", obs_busy[0], 1);
        check("midop valid", obs_valid[0], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async reset a");
        check_zero(1, "async reset b");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after reset busy", obs_busy[0], 0);
        basic_pattern();
        measure(0, 1'b0, 2, 0, 1'b0, 1'b0, "after reset", lat);
        check("after reset latency", lat, BASIC_LAT);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
